// File: rtl/rc_sponge_ctrl.sv
// Sponge controller: absorbs RATE-element blocks into LANES parallel states, runs an external
// permutation core between blocks and presents element 0 of every lane state as the digest.
module rc_sponge_ctrl #(
    parameter int unsigned       N_BITS        = 254,
    parameter int unsigned       STATE_SIZE    = 3,
    parameter int unsigned       RATE          = 2,
    parameter int unsigned       LANES         = 13,
    parameter logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int unsigned       TIMEOUT       = 4096
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [N_BITS-1:0]                         cfg_cap_init,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [LANES-1:0][RATE-1:0][N_BITS-1:0]    in_block,
    input  logic                                      in_last,
    output logic                                      perm_enable,
    output logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_in,
    input  logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] perm_out,
    input  logic                                      perm_done,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES-1:0][N_BITS-1:0]              out_digest,
    output logic [15:0]                               block_count,
    output logic [31:0]                               perm_cycles,
    output logic                                      err_range,
    output logic                                      err_timeout
);

    typedef enum logic [1:0] {StIdle, StPerm, StAbsorb, StSqueeze} ctrlStateE;

    ctrlStateE stateQ, stateD;
    logic [LANES-1:0][STATE_SIZE-1:0][N_BITS-1:0] spongeQ, spongeD;
    logic [15:0] blockCountQ, blockCountD;
    logic [31:0] permCyclesQ, permCyclesD;
    logic [31:0] permTimerQ, permTimerD;
    logic        errRangeQ, errRangeD;
    logic        errTimeoutQ, errTimeoutD;
    logic        lastQ, lastD;
    logic        readyQ, readyD;
    logic        accept;
    logic        blockOutOfRange;

    // Single conditional subtraction; inputs are assumed reduced.
    function automatic logic [N_BITS-1:0] modAdd(input logic [N_BITS-1:0] a,
                                                 input logic [N_BITS-1:0] b);
        logic [N_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, PRIME_MODULUS}) begin
            sum = sum - {1'b0, PRIME_MODULUS};
        end
        return sum[N_BITS-1:0];
    endfunction

    always_comb begin
        blockOutOfRange = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned r = 0; r < RATE; r++) begin
                if (in_block[l][r] >= PRIME_MODULUS) begin
                    blockOutOfRange = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateD      = stateQ;
        spongeD     = spongeQ;
        blockCountD = blockCountQ;
        permCyclesD = permCyclesQ;
        permTimerD  = permTimerQ;
        errRangeD   = errRangeQ;
        errTimeoutD = errTimeoutQ;
        lastD       = lastQ;
        accept      = in_valid && readyQ;

        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        for (int unsigned r = 0; r < RATE; r++) begin
                            spongeD[l][r] = in_block[l][r];
                        end
                        for (int unsigned r = RATE; r < STATE_SIZE; r++) begin
                            spongeD[l][r] = cfg_cap_init;
                        end
                    end
                    blockCountD = 16'd1;
                    permCyclesD = '0;
                    permTimerD  = '0;
                    errRangeD   = blockOutOfRange;
                    errTimeoutD = 1'b0;
                    lastD       = in_last;
                    stateD      = StPerm;
                end
            end
            StAbsorb: begin
                if (accept) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        for (int unsigned r = 0; r < RATE; r++) begin
                            spongeD[l][r] = modAdd(spongeQ[l][r], in_block[l][r]);
                        end
                    end
                    if (blockCountQ != 16'hFFFF) begin
                        blockCountD = blockCountQ + 16'd1;
                    end
                    permTimerD = '0;
                    errRangeD  = errRangeQ | blockOutOfRange;
                    lastD      = in_last;
                    stateD     = StPerm;
                end
            end
            StPerm: begin
                permCyclesD = permCyclesQ + 32'd1;
                permTimerD  = permTimerQ + 32'd1;
                if (perm_done) begin
                    spongeD = perm_out;
                    stateD  = lastQ ? StSqueeze : StAbsorb;
                end else if (permTimerQ == 32'(TIMEOUT - 1)) begin
                    // Give up on the core; digest reflects the pre-permutation state.
                    errTimeoutD = 1'b1;
                    stateD      = StSqueeze;
                end
            end
            StSqueeze: begin
                if (out_ready) begin
                    spongeD = '0;
                    stateD  = StIdle;
                end
            end
        endcase

        readyD = (stateD == StIdle) || (stateD == StAbsorb);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StIdle;
            spongeQ     <= '0;
            blockCountQ <= '0;
            permCyclesQ <= '0;
            permTimerQ  <= '0;
            errRangeQ   <= 1'b0;
            errTimeoutQ <= 1'b0;
            lastQ       <= 1'b0;
            readyQ      <= 1'b0;
        end else begin
            stateQ      <= stateD;
            spongeQ     <= spongeD;
            blockCountQ <= blockCountD;
            permCyclesQ <= permCyclesD;
            permTimerQ  <= permTimerD;
            errRangeQ   <= errRangeD;
            errTimeoutQ <= errTimeoutD;
            lastQ       <= lastD;
            readyQ      <= readyD;
        end
    end

    // in_ready is registered so it stays low while reset is held.
    assign in_ready    = readyQ;
    assign perm_enable = (stateQ == StPerm);
    assign out_valid   = (stateQ == StSqueeze);
    assign perm_in     = spongeQ;
    assign block_count = blockCountQ;
    assign perm_cycles = permCyclesQ;
    assign err_range   = errRangeQ;
    assign err_timeout = errTimeoutQ;

    always_comb begin
        out_digest = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            out_digest[l] = spongeQ[l][0];
        end
    end

endmodule

// File: tb/tb_rc_sponge_ctrl.sv
// Scoreboard bench for rc_sponge_ctrl with a behavioural permutation stub
// (plus-one, identity or never-done modes).
module tb_rc_sponge_ctrl;

    localparam int NB = 254;
    localparam int SS = 3;
    localparam int R  = 2;
    localparam int L  = 13;
    localparam logic [NB-1:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NB-1:0] cfg_cap_init;
    logic in_valid;
    logic in_ready;
    logic [L-1:0][R-1:0][NB-1:0] in_block;
    logic in_last;
    logic perm_enable;
    logic [L-1:0][SS-1:0][NB-1:0] perm_in;
    logic [L-1:0][SS-1:0][NB-1:0] perm_out;
    logic perm_done;
    logic out_valid;
    logic out_ready;
    logic [L-1:0][NB-1:0] out_digest;
    logic [15:0] block_count;
    logic [31:0] perm_cycles;
    logic err_range;
    logic err_timeout;

    int nTests = 0;
    int nFail = 0;
    int stubMode = 0;
    int stubCnt = 0;
    logic doneForce = 1'b0;

    always #5 clk = ~clk;

    rc_sponge_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_cap_init (cfg_cap_init),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .in_last      (in_last),
        .perm_enable  (perm_enable),
        .perm_in      (perm_in),
        .perm_out     (perm_out),
        .perm_done    (perm_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_digest   (out_digest),
        .block_count  (block_count),
        .perm_cycles  (perm_cycles),
        .err_range    (err_range),
        .err_timeout  (err_timeout)
    );

    // Stub core: done on the 6th enabled cycle; mode 0 = +1 mod p, 1 = identity, 2 = never done.
    always @(posedge clk) stubCnt <= perm_enable ? stubCnt + 1 : 0;
    assign perm_done = doneForce | (perm_enable && stubMode != 2 && stubCnt == 5);

    always_comb begin
        logic [NB-1:0] inc;
        perm_out = perm_in;
        for (int l = 0; l < L; l++) begin
            for (int s = 0; s < SS; s++) begin
                inc = perm_in[l][s] + NB'(1);
                if (stubMode == 0) perm_out[l][s] = (inc == P) ? '0 : inc;
            end
        end
    end

    typedef struct {
        string         name;
        logic [NB-1:0] dig;
        int            step;
        int            bc;
        int            pc;
        int            er;
        int            et;
    } expT;

    expT sbQ[$];
    expT e;

    function automatic logic [NB-1:0] laneOff(input int step, input int l);
        logic [NB-1:0] v;
        v = '0;
        v[31:0] = step * l;
        return v;
    endfunction

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expectMsg(input string name, input logic [NB-1:0] dig, input int step,
                             input int bc, input int pc, input int er, input int et);
        expT x;
        x.name = name; x.dig = dig; x.step = step;
        x.bc = bc; x.pc = pc; x.er = er; x.et = et;
        sbQ.push_back(x);
    endtask

    // Monitor: a digest handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpected_digest: got lane0 %0d, expected no output", out_digest[0]);
            end else begin
                e = sbQ.pop_front();
                for (int l = 0; l < L; l++) begin
                    check($sformatf("%s.digest[%0d]", e.name, l), out_digest[l],
                          e.dig + laneOff(e.step, l));
                end
                check({e.name, ".block_count"}, NB'(block_count), NB'(e.bc));
                check({e.name, ".perm_cycles"}, NB'(perm_cycles), NB'(e.pc));
                check({e.name, ".err_range"}, NB'(err_range), NB'(e.er));
                check({e.name, ".err_timeout"}, NB'(err_timeout), NB'(e.et));
            end
        end
    end

    task automatic setBlock(input logic [NB-1:0] a, input logic [NB-1:0] b, input int step,
                            input logic last);
        for (int l = 0; l < L; l++) begin
            in_block[l][0] = a + laneOff(step, l);
            in_block[l][1] = b;
        end
        in_last = last;
    endtask

    // Returns #1 after the accepting edge.
    task automatic sendBlock(input logic [NB-1:0] a, input logic [NB-1:0] b, input int step,
                             input logic last);
        int n;
        setBlock(a, b, step, last);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nTests++;
            nFail++;
            $display("FAIL accept_wait: got in_ready 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int maxCycles);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL drain: got %0d pending digests, expected 0", sbQ.size());
            sbQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cfg_cap_init = '0;
        in_valid = 1'b0;
        in_block = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        #2 reset = 1'b0;
        #1;
        check("rst.in_ready", NB'(in_ready), NB'(0));
        check("rst.perm_enable", NB'(perm_enable), NB'(0));
        check("rst.out_valid", NB'(out_valid), NB'(0));
        check("rst.block_count", NB'(block_count), NB'(0));
        check("rst.perm_cycles", NB'(perm_cycles), NB'(0));
        check("rst.errors", NB'({err_range, err_timeout}), NB'(0));
        check("rst.digest0", out_digest[0], '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_release.in_ready_before_edge", NB'(in_ready), NB'(0));
        @(posedge clk);
        #1 check("rst_release.in_ready_after_edge", NB'(in_ready), NB'(1));

        // Single block, plus-one core.
        stubMode = 0;
        expectMsg("single", NB'(8), 1, 1, 6, 0, 0);
        sendBlock(NB'(7), NB'(5), 1, 1'b1);
        check("single.perm_enable_after_accept", NB'(perm_enable), NB'(1));
        drain(100);
        check("single.hold_block_count", NB'(block_count), NB'(1));
        check("single.hold_perm_cycles", NB'(perm_cycles), NB'(6));
        check("single.idle_in_ready", NB'(in_ready), NB'(1));

        // Two blocks with a capacity domain separator.
        cfg_cap_init = NB'(100);
        expectMsg("two_block", NB'(10), 1, 2, 12, 0, 0);
        sendBlock(NB'(7), NB'(5), 1, 1'b0);
        check("two_block.perm_enable", NB'(perm_enable), NB'(1));
        check("two_block.load_r0", perm_in[0][0], NB'(7));
        check("two_block.load_r1", perm_in[0][1], NB'(5));
        check("two_block.load_cap", perm_in[0][2], NB'(100));
        sendBlock(NB'(1), NB'(2), 0, 1'b1);
        check("two_block.absorb_r0", perm_in[0][0], NB'(9));
        check("two_block.absorb_r1", perm_in[0][1], NB'(8));
        check("two_block.absorb_cap", perm_in[0][2], NB'(101));
        drain(100);

        // Identity core: wrap through p, then an out-of-range element.
        cfg_cap_init = '0;
        stubMode = 1;
        expectMsg("wrap", NB'(1), 1, 2, 12, 0, 0);
        sendBlock(P - NB'(1), '0, 0, 1'b0);
        sendBlock(NB'(2), '0, 1, 1'b1);
        drain(100);
        expectMsg("range", NB'(5), 1, 2, 12, 1, 0);
        sendBlock(NB'(5), '0, 1, 1'b0);
        sendBlock(P, '0, 0, 1'b1);
        drain(100);

        // Core never finishes.
        stubMode = 2;
        expectMsg("timeout", NB'(7), 1, 1, 4096, 0, 1);
        sendBlock(NB'(7), NB'(5), 1, 1'b1);
        drain(5000);

        // Back-pressured digest with a queued next message.
        stubMode = 0;
        out_ready = 1'b0;
        expectMsg("hold", NB'(8), 1, 1, 6, 0, 0);
        expectMsg("queued", NB'(21), 1, 1, 6, 0, 0);
        sendBlock(NB'(7), NB'(5), 1, 1'b1);
        setBlock(NB'(20), '0, 1, 1'b1);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold.out_valid_seen", NB'(out_valid), NB'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold.digest0_c%0d", i), out_digest[0], NB'(8));
            check($sformatf("hold.in_ready_c%0d", i), NB'(in_ready), NB'(0));
            check($sformatf("hold.out_valid_c%0d", i), NB'(out_valid), NB'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queued.accepted", NB'(in_ready), NB'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain(100);

        // Reset in the middle of a permutation.
        sendBlock(NB'(7), NB'(5), 1, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst.perm_enable", NB'(perm_enable), NB'(0));
        check("mid_rst.in_ready", NB'(in_ready), NB'(0));
        check("mid_rst.block_count", NB'(block_count), NB'(0));
        check("mid_rst.digest0", out_digest[0], '0);
        @(negedge clk);
        reset = 1'b1;
        doneForce = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("mid_rst.out_valid_c%0d", i), NB'(out_valid), NB'(0));
            check($sformatf("mid_rst.perm_enable_c%0d", i), NB'(perm_enable), NB'(0));
            check($sformatf("mid_rst.in_ready_c%0d", i), NB'(in_ready), NB'(1));
            if (i == 2) doneForce = 1'b0;
        end
        check("mid_rst.no_pending", NB'(sbQ.size()), NB'(0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/rc_sponge_ctrl.md
RC_SPONGE_CTRL -- requirements
Module: rc_sponge_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_BITS, 254, field element width.
- STATE_SIZE, 3, permutation state width in elements.
- RATE, 2, absorbed elements per block; RATE < STATE_SIZE.
- LANES, 13, independent messages hashed in parallel.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p.
- TIMEOUT, 4096, maximum cycles spent in PERM.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- cfg_cap_init, in, N_BITS, capacity initial value (domain separator), sampled on the first accepted block.
- in_valid, in, 1, input block valid.
- in_ready, out, 1, controller accepts a block.
- in_block, in, LANES x RATE x N_BITS, one block per lane.
- in_last, in, 1, block is the final block of the message.
- perm_enable, out, 1, permutation core run request (level).
- perm_in, out, LANES x STATE_SIZE x N_BITS, state presented to the core.
- perm_out, in, LANES x STATE_SIZE x N_BITS, core result.
- perm_done, in, 1, core result valid (level).
- out_valid, out, 1, digest valid.
- out_ready, in, 1, digest consumed.
- out_digest, out, LANES x N_BITS, element 0 of each lane state.
- block_count, out, 16, blocks absorbed in the current message.
- perm_cycles, out, 32, cycles spent in PERM during the current message.
- err_range, out, 1, sticky per message: some input element was >= p.
- err_timeout, out, 1, sticky per message: PERM exceeded TIMEOUT.

Function
REQ-003 The FSM SHALL have states IDLE, PERM, ABSORB and SQUEEZE.
REQ-004 in_ready SHALL be 1 only in IDLE and ABSORB; a block SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-005 On accept in IDLE, the controller SHALL load state[l][r] = in_block[l][r] for r < RATE, and load every capacity element r >= RATE with cfg_cap_init.
- On the same accept it SHALL clear err_range, err_timeout and perm_cycles, set block_count=1, latch in_last, and go to PERM.
REQ-006 On accept in ABSORB, the controller SHALL update state[l][r] = (state[l][r] + in_block[l][r]) mod p for r < RATE, leave the capacity unchanged, increment block_count (saturating at 16'hFFFF), latch in_last, and go to PERM.
REQ-007 Modular addition SHALL form an (N_BITS+1)-bit sum and subtract p once if the sum is >= p; operands are reduced values.
REQ-008 Any accepted in_block element >= p SHALL set err_range; the element SHALL still be absorbed unreduced-checked (same add rule).
REQ-009 In PERM, perm_enable SHALL be 1, perm_in SHALL equal the state register, and perm_cycles SHALL increment every cycle.
REQ-010 perm_enable SHALL rise on the cycle after the accept.
REQ-011 On perm_done=1 in PERM, the controller SHALL load state from perm_out and go to SQUEEZE if the latched last flag is 1, else to ABSORB.
- perm_enable SHALL be 0 on the following cycle and SHALL stay 0 for at least one cycle between runs.
REQ-012 perm_done SHALL be ignored outside PERM.
REQ-013 If the controller has spent TIMEOUT cycles in PERM without perm_done, it SHALL set err_timeout and go to SQUEEZE; state is not updated.
REQ-014 In SQUEEZE, out_valid SHALL be 1 and out_digest[l] SHALL equal state[l][0]; outputs SHALL hold stable until out_ready=1.
- On out_valid=1 and out_ready=1 the controller SHALL go to IDLE and clear the state.
- block_count, perm_cycles and the error flags SHALL hold until the next message starts.
REQ-015 in_valid arriving during PERM or SQUEEZE SHALL be stalled (in_ready=0) and no data SHALL be lost.
REQ-016 Minimum latency for a single-block message SHALL be 1 accept cycle + core latency + 1 cycle to out_valid.

Reset
REQ-017 While reset=0, the following SHALL be cleared asynchronously: FSM to IDLE, in_ready to 0, perm_enable, out_valid, err_range, err_timeout, block_count, perm_cycles, state and out_digest.
REQ-018 On the first clock edge after reset deasserts, in_ready SHALL become 1.
REQ-019 Reset during PERM SHALL drop perm_enable immediately; a perm_done arriving afterwards SHALL be ignored.

Verification
REQ-020 Bench stub core: perm_out = perm_in + 1 mod p per element, perm_done after 5 cycles. Lane0 block [7,5], last=1, cap 0 -> digest 8, block_count 1, perm_cycles 6.
REQ-021 Same stub: [7,5] then [1,2] with last -> state [8,6,1] becomes [9,8,1], then [10,9,2]; digest 10, block_count 2.
REQ-022 Identity stub: blocks [p-1,0] then [2,0] with last -> digest 1 (wrap through p).
REQ-023 Stub never asserts perm_done -> err_timeout=1 after 4096 PERM cycles, then out_valid=1 with digest unchanged from the pre-PERM state.
REQ-024 Real rcPermutation core, lane0 [7,5], cap 0, single block -> digest 12360106593270449844061412657301362366573579256583003766552363058581964117186.
REQ-025 Hold out_ready=0 for 10 cycles with in_valid=1 -> digest stable and in_ready=0 throughout; reset pulsed mid-PERM -> IDLE, no out_valid.
